// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side drain stage placed directly after a synchronous FIFO. It pops
// BURST_LEN words per burst once that many are stored, or drains all stored
// words as a partial burst while flush is high. The FIFO has a one-cycle
// read latency, so returning words land in a 2-entry output buffer. The
// consumer sees a valid/ready stream with an end-of-burst marker.
//
// Optional feature (macro BURST_CNT_EN): adds burst_count[15:0], a wrapping
// count of completed bursts.
//
// Ports:
//   fifo_clk         in   clock, rising edge
//   rst              in   synchronous reset, active-high
//   fifo_empty       in   FIFO empty flag
//   fifo_data_avail  in   occupied FIFO entries [FIFO_PTR:0]
//   fifo_rddata      in   FIFO read data, valid the cycle after fifo_rden
//   fifo_rden        out  FIFO pop strobe (combinational)
//   flush            in   level; permits a partial burst of all stored words
//   out_valid        out  out_data/out_last valid
//   out_ready        in   consumer ready
//   out_data         out  output word
//   out_last         out  final word of the current burst
//   busy             out  high whenever the FSM is not IDLE
//   state_dbg        out  raw FSM state (0=IDLE, 1=BURST)
//   burst_count      out  completed-burst counter (BURST_CNT_EN only)
//
// Handshake: a word transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is high, out_data and out_last
// hold steady until that transfer; out_valid never drops without a transfer
// (except on rst).
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int FIFO_PTR   = 4,
  parameter int FIFO_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  fifo_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [FIFO_PTR:0]     fifo_data_avail,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  output logic                  fifo_rden,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [0:0]            state_dbg
`ifdef BURST_CNT_EN
  ,
  output logic [15:0]           burst_count
`endif
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [FIFO_PTR:0] BURST_LEN_W = (FIFO_PTR+1)'(BURST_LEN);
  localparam logic [FIFO_PTR:0] ONE_W       = (FIFO_PTR+1)'(1);

  logic [0:0]            state;
  logic [FIFO_PTR:0]     len;       // words in the current burst
  logic [FIFO_PTR:0]     issued;    // pops issued this burst
  logic [FIFO_PTR:0]     accepted;  // words accepted this burst
  logic                  inflight;  // fifo_rddata is valid this cycle
  logic                  inflight_last;

  logic [FIFO_WIDTH-1:0] buf_data [2];
  logic                  buf_last [2];
  logic [1:0]            buf_cnt;

  logic                  pop;
  logic                  push;
  logic                  done;
  logic                  last_issue;
  logic [2:0]            occ_after;

  assign pop  = out_valid && out_ready;
  assign push = inflight;
  assign done = pop && out_last;

  // Slots still committed after this cycle's pop; a new pop is only issued
  // when its returning word is guaranteed a buffer entry.
  assign occ_after  = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign last_issue = (issued == (len - ONE_W));

  assign fifo_rden = (state == BURST) && !fifo_empty && (issued < len) &&
                     (occ_after < 3'd2);

  assign out_valid = (buf_cnt != 2'd0);
  assign out_data  = buf_data[0];
  assign out_last  = buf_last[0] && out_valid;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // FSM and burst bookkeeping
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      state         <= IDLE;
      len           <= '0;
      issued        <= '0;
      accepted      <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= fifo_rden;
      inflight_last <= fifo_rden && last_issue;
      case (state)
        IDLE: begin
          issued   <= '0;
          accepted <= '0;
          if (fifo_data_avail >= BURST_LEN_W) begin
            state <= BURST;
            len   <= BURST_LEN_W;
          end else if (flush && (fifo_data_avail != '0)) begin
            state <= BURST;
            len   <= fifo_data_avail;
          end
        end
        BURST: begin
          if (fifo_rden) issued <= issued + ONE_W;
          if (pop) accepted <= accepted + ONE_W;
          if (done) begin
            state    <= IDLE;
            issued   <= '0;
            accepted <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // 2-entry output buffer; entry 0 is the head driving the outputs.
  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_last[i] <= 1'b0;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          buf_data[buf_cnt[0]] <= fifo_rddata;
          buf_last[buf_cnt[0]] <= inflight_last;
          buf_cnt              <= buf_cnt + 2'd1;
        end
        2'b01: begin
          buf_data[0] <= buf_data[1];
          buf_last[0] <= buf_last[1];
          buf_cnt     <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            buf_data[0] <= fifo_rddata;
            buf_last[0] <= inflight_last;
          end else begin
            buf_data[0] <= buf_data[1];
            buf_last[0] <= buf_last[1];
            buf_data[1] <= fifo_rddata;
            buf_last[1] <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BURST_CNT_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge fifo_clk) begin
    if (rst) begin
      burst_cnt_q <= 16'd0;
    end else if (done) begin
      burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

  assign burst_count = burst_cnt_q;
`endif

endmodule
